// File: rtl/dual_fetch.sv
// Two-wide instruction fetch front end: fetch PC plus a 4-entry {inst, pc} queue.
// Each push enqueues an aligned pair fetched from an async-read memory port.
module dual_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic [31:0] im_data1,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic [1:0]  dec_take,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1
);

  logic [31:0] pc, pc_nxt;
  logic [31:0] q_inst [QDEPTH];
  logic [31:0] q_pc   [QDEPTH];
  logic [31:0] nq_inst [QDEPTH];
  logic [31:0] nq_pc   [QDEPTH];
  logic [2:0]  count, count_nxt;
  logic [2:0]  take, pops, rem;
  logic        push;
  logic        unused_pc_bits;

  // The target's low two bits are forced to zero, so they never reach state.
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign im_addr = pc;

  always_comb begin
    take      = (dec_take == 2'd3) ? 3'd2 : {1'b0, dec_take};
    pops      = (take > count) ? count : take;
    rem       = count - pops;
    push      = !redirect && !halt && (rem <= 3'd2);
    count_nxt = push ? rem + 3'd2 : rem;
    pc_nxt    = push ? pc + 32'd8 : pc;
    for (int i = 0; i < QDEPTH; i++) begin
      nq_inst[i] = 32'h0;
      nq_pc[i]   = 32'h0;
      // Survivors slide down by the pop count; the new pair lands right behind them.
      if (i < int'(rem)) begin
        nq_inst[i] = q_inst[2'(i + int'(pops))];
        nq_pc[i]   = q_pc[2'(i + int'(pops))];
      end else if (push && i == int'(rem)) begin
        nq_inst[i] = im_data;
        nq_pc[i]   = pc;
      end else if (push && i == int'(rem) + 1) begin
        nq_inst[i] = im_data1;
        nq_pc[i]   = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= 3'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= 32'h0;
        q_pc[i]   <= 32'h0;
      end
    end else if (redirect) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      count <= 3'd0;
    end else begin
      pc     <= pc_nxt;
      count  <= count_nxt;
      q_inst <= nq_inst;
      q_pc   <= nq_pc;
    end
  end

  assign out_valid0 = (count > 3'd0);
  assign out_valid1 = (count > 3'd1);
  assign out_inst0  = out_valid0 ? q_inst[0] : 32'h0;
  assign out_inst1  = out_valid1 ? q_inst[1] : 32'h0;
  assign out_pc0    = out_valid0 ? q_pc[0]   : 32'h0;
  assign out_pc1    = out_valid1 ? q_pc[1]   : 32'h0;

endmodule
